// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use and
// multiply/divide stalls, redirect flushes, and EX-stage operand forwarding selects.
module hazard_ctrl #(
    parameter int MD_LAT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs_D,
    input  logic [4:0] Rt_D,
    input  logic       uses_rs_D,
    input  logic       uses_rt_D,
    input  logic       md_start_D,
    input  logic       md_use_D,
    input  logic [4:0] Rs_E,
    input  logic [4:0] Rt_E,
    input  logic [4:0] WriteReg_E,
    input  logic       RegWr_E,
    input  logic       MemtoReg_E,
    input  logic       md_start_E,
    input  logic       taken_E,
    input  logic [4:0] WriteReg_M,
    input  logic [4:0] WriteReg_W,
    input  logic       RegWr_M,
    input  logic       RegWr_W,
    output logic       stall_F,
    output logic       stall_D,
    output logic       flush_D,
    output logic       flush_E,
    output logic [1:0] fwdA_E,
    output logic [1:0] fwdB_E,
    output logic       md_busy
);

    localparam int CNT_W = $clog2(MD_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             md_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter holds the number of busy cycles still to come; a new
    // md_start_E while busy cannot happen because ID is held on md_start_D.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (md_start_E) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        md_busy  = (state_q == BUSY);
        load_use = RegWr_E && MemtoReg_E && (WriteReg_E != 5'd0) &&
                   ((uses_rs_D && (Rs_D == WriteReg_E)) ||
                    (uses_rt_D && (Rt_D == WriteReg_E)));
        md_hold  = md_busy && (md_use_D || md_start_D);

        stall_F = 1'b0;
        stall_D = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        // A taken redirect outranks any stall: the ID instruction is wrong-path.
        if (!rst_n || taken_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else if (load_use || md_hold) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end
    end

    always_comb begin
        fwdA_E = 2'b00;
        fwdB_E = 2'b00;
        if (RegWr_M && (WriteReg_M != 5'd0) && (WriteReg_M == Rs_E)) begin
            fwdA_E = 2'b10;
        end else if (RegWr_W && (WriteReg_W != 5'd0) && (WriteReg_W == Rs_E)) begin
            fwdA_E = 2'b01;
        end
        if (RegWr_M && (WriteReg_M != 5'd0) && (WriteReg_M == Rt_E)) begin
            fwdB_E = 2'b10;
        end else if (RegWr_W && (WriteReg_W != 5'd0) && (WriteReg_W == Rt_E)) begin
            fwdB_E = 2'b01;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized cycles checked
// against a cycle-stamp model of the multiply/divide busy window.
module tb_hazard_ctrl;

    localparam int MD_LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
    logic       uses_rs_D, uses_rt_D, md_start_D, md_use_D;
    logic       RegWr_E, MemtoReg_E, md_start_E, taken_E, RegWr_M, RegWr_W;
    logic       stall_F, stall_D, flush_D, flush_E, md_busy;
    logic [1:0] fwdA_E, fwdB_E;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: the unit is busy while the edge count is below busy_end.
    int edge_cnt = 0;
    int busy_end = 0;

    hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .uses_rs_D(uses_rs_D), .uses_rt_D(uses_rt_D),
        .md_start_D(md_start_D), .md_use_D(md_use_D),
        .Rs_E(Rs_E), .Rt_E(Rt_E), .WriteReg_E(WriteReg_E),
        .RegWr_E(RegWr_E), .MemtoReg_E(MemtoReg_E), .md_start_E(md_start_E),
        .taken_E(taken_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWr_M(RegWr_M), .RegWr_W(RegWr_W),
        .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) busy_end <= edge_cnt;
        else if (md_start_E && !(edge_cnt < busy_end)) busy_end <= edge_cnt + MD_LAT;
        edge_cnt <= edge_cnt + 1;
    end

    task automatic clear_inputs();
        Rs_D = 0; Rt_D = 0; uses_rs_D = 0; uses_rt_D = 0; md_start_D = 0; md_use_D = 0;
        Rs_E = 0; Rt_E = 0; WriteReg_E = 0; RegWr_E = 0; MemtoReg_E = 0;
        md_start_E = 0; taken_E = 0; WriteReg_M = 0; WriteReg_W = 0;
        RegWr_M = 0; RegWr_W = 0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        Rs_E = 5'd3; WriteReg_M = 5'd3; RegWr_M = 1'b1;
        repeat (2) @(posedge clk);
        next_cycle(); #1;
        n_checks++; if (flush_D !== 1'b1) $display("[TB] FAIL rst_flush_D: got %b want 1", flush_D); else n_pass++;
        n_checks++; if (flush_E !== 1'b1) $display("[TB] FAIL rst_flush_E: got %b want 1", flush_E); else n_pass++;
        n_checks++; if (stall_F !== 1'b0) $display("[TB] FAIL rst_stall_F: got %b want 0", stall_F); else n_pass++;
        n_checks++; if (stall_D !== 1'b0) $display("[TB] FAIL rst_stall_D: got %b want 0", stall_D); else n_pass++;
        n_checks++; if (md_busy !== 1'b0) $display("[TB] FAIL rst_md_busy: got %b want 0", md_busy); else n_pass++;
        n_checks++; if (fwdA_E !== 2'b10) $display("[TB] FAIL rst_fwdA: got %b want 10", fwdA_E); else n_pass++;
        clear_inputs();
        rst_n = 1'b1;
        #1;
        n_checks++; if (flush_D !== 1'b0) $display("[TB] FAIL rst_release_flush_D: got %b want 0", flush_D); else n_pass++;
    endtask

    task automatic test_load_use();
        next_cycle(); clear_inputs();
        RegWr_E = 1; MemtoReg_E = 1; WriteReg_E = 5'd8; uses_rs_D = 1; Rs_D = 5'd8;
        #1;
        n_checks++; if (stall_F !== 1'b1) $display("[TB] FAIL lu_stall_F: got %b want 1", stall_F); else n_pass++;
        n_checks++; if (stall_D !== 1'b1) $display("[TB] FAIL lu_stall_D: got %b want 1", stall_D); else n_pass++;
        n_checks++; if (flush_E !== 1'b1) $display("[TB] FAIL lu_flush_E: got %b want 1", flush_E); else n_pass++;
        n_checks++; if (flush_D !== 1'b0) $display("[TB] FAIL lu_flush_D: got %b want 0", flush_D); else n_pass++;
        // Bubble in EX, load in MEM: consumer still in ID must not stall again.
        next_cycle(); clear_inputs();
        uses_rs_D = 1; Rs_D = 5'd8; RegWr_M = 1; WriteReg_M = 5'd8;
        #1;
        n_checks++; if (stall_F !== 1'b0) $display("[TB] FAIL lu_release_stall: got %b want 0", stall_F); else n_pass++;
        next_cycle(); clear_inputs();
        Rs_E = 5'd8; RegWr_W = 1; WriteReg_W = 5'd8;
        #1;
        n_checks++; if (fwdA_E !== 2'b01) $display("[TB] FAIL lu_wb_fwd: got %b want 01", fwdA_E); else n_pass++;
        next_cycle(); clear_inputs();
        Rs_E = 5'd8; RegWr_M = 1; WriteReg_M = 5'd8;
        #1;
        n_checks++; if (fwdA_E !== 2'b10) $display("[TB] FAIL nonload_mem_fwd: got %b want 10", fwdA_E); else n_pass++;
        next_cycle(); clear_inputs();
        RegWr_E = 1; MemtoReg_E = 1; WriteReg_E = 5'd9; uses_rt_D = 1; Rt_D = 5'd9; Rs_D = 5'd9;
        #1;
        n_checks++; if (stall_D !== 1'b1) $display("[TB] FAIL lu_rt_stall: got %b want 1", stall_D); else n_pass++;
    endtask

    task automatic test_forward_priority();
        next_cycle(); clear_inputs();
        Rs_E = 5'd5; Rt_E = 5'd5; WriteReg_M = 5'd5; WriteReg_W = 5'd5; RegWr_M = 1; RegWr_W = 1;
        #1;
        n_checks++; if (fwdA_E !== 2'b10) $display("[TB] FAIL fwdA_mem_over_wb: got %b want 10", fwdA_E); else n_pass++;
        n_checks++; if (fwdB_E !== 2'b10) $display("[TB] FAIL fwdB_mem_over_wb: got %b want 10", fwdB_E); else n_pass++;
        RegWr_M = 0; #1;
        n_checks++; if (fwdA_E !== 2'b01) $display("[TB] FAIL fwdA_wb_only: got %b want 01", fwdA_E); else n_pass++;
        n_checks++; if (fwdB_E !== 2'b01) $display("[TB] FAIL fwdB_wb_only: got %b want 01", fwdB_E); else n_pass++;
        RegWr_M = 1; WriteReg_M = 5'd0; Rs_E = 5'd0; #1;
        n_checks++; if (fwdA_E !== 2'b00) $display("[TB] FAIL fwdA_zero: got %b want 00", fwdA_E); else n_pass++;
    endtask

    task automatic test_md_stall();
        next_cycle(); clear_inputs();
        md_start_E = 1;
        for (int i = 1; i <= MD_LAT - 1; i++) begin
            next_cycle(); clear_inputs();
            md_use_D = 1;
            if (i == 2) begin
                RegWr_E = 1; MemtoReg_E = 1; WriteReg_E = 5'd4; uses_rs_D = 1; Rs_D = 5'd4;
            end
            #1;
            n_checks++; if (md_busy !== 1'b1) $display("[TB] FAIL md_busy_c%0d: got %b want 1", i, md_busy); else n_pass++;
            n_checks++; if (stall_F !== 1'b1) $display("[TB] FAIL md_stall_F_c%0d: got %b want 1", i, stall_F); else n_pass++;
            n_checks++; if (flush_E !== 1'b1) $display("[TB] FAIL md_flush_E_c%0d: got %b want 1", i, flush_E); else n_pass++;
            n_checks++; if (flush_D !== 1'b0) $display("[TB] FAIL md_flush_D_c%0d: got %b want 0", i, flush_D); else n_pass++;
        end
        next_cycle(); clear_inputs();
        md_use_D = 1; #1;
        n_checks++; if (md_busy !== 1'b0) $display("[TB] FAIL md_busy_end: got %b want 0", md_busy); else n_pass++;
        n_checks++; if (stall_D !== 1'b0) $display("[TB] FAIL md_release: got %b want 0", stall_D); else n_pass++;
    endtask

    task automatic test_redirect();
        next_cycle(); clear_inputs();
        md_start_E = 1;
        next_cycle(); clear_inputs();
        md_use_D = 1; taken_E = 1; #1;
        n_checks++; if (flush_D !== 1'b1) $display("[TB] FAIL redir_flush_D: got %b want 1", flush_D); else n_pass++;
        n_checks++; if (flush_E !== 1'b1) $display("[TB] FAIL redir_flush_E: got %b want 1", flush_E); else n_pass++;
        n_checks++; if (stall_F !== 1'b0) $display("[TB] FAIL redir_stall_F: got %b want 0", stall_F); else n_pass++;
        n_checks++; if (stall_D !== 1'b0) $display("[TB] FAIL redir_stall_D: got %b want 0", stall_D); else n_pass++;
        n_checks++; if (md_busy !== 1'b1) $display("[TB] FAIL redir_busy: got %b want 1", md_busy); else n_pass++;
        for (int i = 2; i <= MD_LAT; i++) begin
            next_cycle(); clear_inputs(); #1;
            n_checks++;
            if (md_busy !== (i < MD_LAT)) $display("[TB] FAIL redir_cnt_c%0d: got %b want %b", i, md_busy, (i < MD_LAT));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_busy();
        next_cycle(); clear_inputs();
        md_start_E = 1;
        next_cycle(); clear_inputs();
        next_cycle(); clear_inputs();
        md_use_D = 1; rst_n = 0; #1;
        n_checks++; if (flush_D !== 1'b1) $display("[TB] FAIL rmb_flush_D: got %b want 1", flush_D); else n_pass++;
        n_checks++; if (flush_E !== 1'b1) $display("[TB] FAIL rmb_flush_E: got %b want 1", flush_E); else n_pass++;
        n_checks++; if (stall_F !== 1'b0) $display("[TB] FAIL rmb_stall_F: got %b want 0", stall_F); else n_pass++;
        next_cycle(); rst_n = 1; #1;
        n_checks++; if (md_busy !== 1'b0) $display("[TB] FAIL rmb_busy: got %b want 0", md_busy); else n_pass++;
        n_checks++; if (stall_F !== 1'b0) $display("[TB] FAIL rmb_no_hold: got %b want 0", stall_F); else n_pass++;
    endtask

    task automatic test_zero_reg();
        next_cycle(); clear_inputs();
        RegWr_E = 1; MemtoReg_E = 1; WriteReg_E = 5'd0; uses_rs_D = 1; uses_rt_D = 1;
        RegWr_M = 1; WriteReg_M = 5'd0; RegWr_W = 1; WriteReg_W = 5'd0;
        #1;
        n_checks++; if (stall_F !== 1'b0) $display("[TB] FAIL zero_no_stall: got %b want 0", stall_F); else n_pass++;
        n_checks++; if (fwdA_E !== 2'b00) $display("[TB] FAIL zero_fwdA: got %b want 00", fwdA_E); else n_pass++;
        n_checks++; if (fwdB_E !== 2'b00) $display("[TB] FAIL zero_fwdB: got %b want 00", fwdB_E); else n_pass++;
    endtask

    task automatic test_random();
        logic       m_busy, lu, hold;
        logic       e_sF, e_sD, e_fD, e_fE;
        logic [1:0] e_fa, e_fb;
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            rst_n      = ($urandom_range(0, 19) != 0);
            Rs_D       = 5'($urandom_range(0, 3)); Rt_D = 5'($urandom_range(0, 3));
            uses_rs_D  = 1'($urandom); uses_rt_D = 1'($urandom);
            md_start_D = ($urandom_range(0, 5) == 0); md_use_D = ($urandom_range(0, 3) == 0);
            Rs_E       = 5'($urandom_range(0, 3)); Rt_E = 5'($urandom_range(0, 3));
            WriteReg_E = 5'($urandom_range(0, 3)); RegWr_E = 1'($urandom); MemtoReg_E = 1'($urandom);
            md_start_E = ($urandom_range(0, 5) == 0); taken_E = ($urandom_range(0, 7) == 0);
            WriteReg_M = 5'($urandom_range(0, 3)); RegWr_M = 1'($urandom);
            WriteReg_W = 5'($urandom_range(0, 3)); RegWr_W = 1'($urandom);
            #1;
            m_busy = (edge_cnt < busy_end);
            lu = RegWr_E && MemtoReg_E && WriteReg_E != 0 &&
                 ((uses_rs_D && Rs_D == WriteReg_E) || (uses_rt_D && Rt_D == WriteReg_E));
            hold = m_busy && (md_use_D || md_start_D);
            {e_sF, e_sD, e_fD, e_fE} = 4'b0000;
            if (!rst_n || taken_E) {e_fD, e_fE} = 2'b11;
            else if (lu || hold) {e_sF, e_sD, e_fE} = 3'b111;
            e_fa = (RegWr_M && WriteReg_M != 0 && WriteReg_M == Rs_E) ? 2'd2 :
                   (RegWr_W && WriteReg_W != 0 && WriteReg_W == Rs_E) ? 2'd1 : 2'd0;
            e_fb = (RegWr_M && WriteReg_M != 0 && WriteReg_M == Rt_E) ? 2'd2 :
                   (RegWr_W && WriteReg_W != 0 && WriteReg_W == Rt_E) ? 2'd1 : 2'd0;
            n_checks++; if (md_busy !== m_busy) $display("[TB] FAIL rnd%0d_busy: got %b want %b", c, md_busy, m_busy); else n_pass++;
            n_checks++; if (stall_F !== e_sF) $display("[TB] FAIL rnd%0d_stall_F: got %b want %b", c, stall_F, e_sF); else n_pass++;
            n_checks++; if (stall_D !== e_sD) $display("[TB] FAIL rnd%0d_stall_D: got %b want %b", c, stall_D, e_sD); else n_pass++;
            n_checks++; if (flush_D !== e_fD) $display("[TB] FAIL rnd%0d_flush_D: got %b want %b", c, flush_D, e_fD); else n_pass++;
            n_checks++; if (flush_E !== e_fE) $display("[TB] FAIL rnd%0d_flush_E: got %b want %b", c, flush_E, e_fE); else n_pass++;
            n_checks++; if (fwdA_E !== e_fa) $display("[TB] FAIL rnd%0d_fwdA: got %b want %b", c, fwdA_E, e_fa); else n_pass++;
            n_checks++; if (fwdB_E !== e_fb) $display("[TB] FAIL rnd%0d_fwdB: got %b want %b", c, fwdB_E, e_fb); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_forward_priority();
        test_md_stall();
        test_redirect();
        test_reset_mid_busy();
        test_zero_reg();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It drives the stall and flush inputs of the IF/ID and ID/EX pipeline registers, and produces the operand-forwarding selects for the EX stage. It also tracks a multi-cycle multiply/divide unit so that HI/LO readers and new MD operations are held in ID until the unit is free. The block sits beside the datapath and observes register fields and control bits from the D, E, M and W stages.

## Interface
- MD_LAT, 32, total multiply/divide latency in cycles including the EX cycle; legal range 2..64
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- Rs_D, Rt_D  in  5 each  source register numbers of the instruction in ID
- uses_rs_D, uses_rt_D  in  1 each  ID instruction actually reads Rs / Rt
- md_start_D  in  1  ID instruction is a mult/div
- md_use_D  in  1  ID instruction reads HI/LO (mfhi/mflo)
- Rs_E, Rt_E, WriteReg_E  in  5 each  EX-stage source and destination register numbers
- RegWr_E, MemtoReg_E  in  1 each  EX-stage write-enable and load flag
- md_start_E  in  1  EX instruction is a mult/div
- taken_E  in  1  branch/jump in EX is taken (redirect)
- WriteReg_M, WriteReg_W  in  5 each  MEM and WB destination register numbers
- RegWr_M, RegWr_W  in  1 each  MEM and WB write-enables
- stall_F  out  1  hold the PC
- stall_D  out  1  hold the IF/ID register
- flush_D  out  1  clear the IF/ID register to a bubble
- flush_E  out  1  clear the ID/EX register to a bubble
- fwdA_E, fwdB_E  out  2 each  EX operand source: 00 = register file, 01 = WB result, 10 = MEM ALU result
- md_busy  out  1  MD unit is executing

## Operation
- **Clocking:** one clock, clk. Reset is synchronous and active-low (rst_n).
- **State machine:** two states, RUN and BUSY, plus a cnt register of $clog2(MD_LAT) bits.
  - RUN → BUSY on a rising edge with md_start_E=1; cnt loads MD_LAT-1.
  - In BUSY, cnt decrements by 1 each edge. At the edge where cnt=1, cnt goes to 0 and the state returns to RUN.
  - md_start_E while in BUSY is ignored (the stall rule below makes it unreachable).
  - md_busy = (state == BUSY).
- **load_use** = RegWr_E & MemtoReg_E & (WriteReg_E≠0) & ((uses_rs_D & Rs_D==WriteReg_E) | (uses_rt_D & Rt_D==WriteReg_E)).
- **md_hold** = md_busy & (md_use_D | md_start_D).
- **Priority of outputs:**
  1. rst_n=0: flush_D=flush_E=1, stall_F=stall_D=0.
  2. taken_E=1: flush_D=flush_E=1, stall_F=stall_D=0. The redirect wins over any stall, because the ID instruction is wrong-path. The MD counter is unaffected.
  3. load_use | md_hold: stall_F=stall_D=flush_E=1, flush_D=0.
  4. Otherwise: all four outputs are 0.
- **Forwarding (per operand; A uses Rs_E, B uses Rt_E):**
  - 10 if RegWr_M & WriteReg_M≠0 & WriteReg_M==src.
  - Else 01 if RegWr_W & WriteReg_W≠0 & WriteReg_W==src.
  - Else 00.
  - MEM has priority over WB, so the newest value wins.
- **Register $0:** never causes a stall or a forward.

## Timing
- **Reset values:** state=RUN, cnt=0, md_busy=0. While rst_n=0, fwdA_E/fwdB_E follow their inputs combinationally.
- **Combinational outputs:** stall, flush and forward outputs depend on the current-cycle inputs and on registered state only. There is no added latency.
- **Load-use:** exactly one bubble. On the next edge the load moves to MEM, load_use drops, and the consumer takes the WB forward one cycle later.
- **MD busy window:** md_busy is high for exactly MD_LAT-1 cycles after the edge that sampled md_start_E.
  - A dependent mfhi in ID is stalled for those cycles.
  - It advances to EX on the first edge after md_busy falls.
- **Simultaneous load_use and md_hold:** a single stall, with the same outputs.
- **rst_n low mid-BUSY:** the block returns to RUN with cnt=0 at that edge.

## Test plan
- **Load-use:** lw $8 in EX (RegWr_E=1, MemtoReg_E=1, WriteReg_E=8), ID reads Rs_D=8 → stall_F=stall_D=flush_E=1 for 1 cycle. The next cycle, with WriteReg_M=8, gives fwdA_E=10 after a non-load, and WB forwarding gives 01.
- **Forward priority:** Rs_E=5, WriteReg_M=5 and WriteReg_W=5, both writing → fwdA_E=10. With RegWr_M=0 → 01. With WriteReg_M=0 and Rs_E=0 → 00.
- **MD stall:** MD_LAT=4, md_start_E pulse at edge k → md_busy high for cycles k+1..k+3. mfhi held in ID for those 3 cycles with flush_E=1, released at edge k+4.
- **Redirect during stall:** md_busy=1, md_use_D=1, taken_E=1 → flush_D=flush_E=1, stall_F=0. The counter keeps decrementing.
- **Reset mid-BUSY:** rst_n=0 for 1 edge with cnt=2 → md_busy=0 the next cycle, and flush_D=flush_E=1 while rst_n is low.
- **$0 hazards:** lw to $0 in EX with uses_rs_D=1 and Rs_D=0 → no stall. A $0 destination in MEM/WB → no forward.
